// File: rtl/counter_seq_checker_pkg.sv
// Shared definitions for the counter sequence checker: state encoding and
// default widths.
package counter_seq_checker_pkg;

  // Checker states; ST_3 is never entered and is treated as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_3      = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_ERR_W = 8;

endpackage

// File: rtl/counter_seq_checker_sat_counter.sv
// Saturating incrementer with synchronous clear. When clear and inc arrive
// together the clear is applied first, so the result is 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count increments, sticking at all-ones; clear wins over the held value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= inc ? W'(1) : '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/counter_seq_checker.sv
// Reader-side monitor for the enable-gated up-counter. Predicts each sample
// from the previous one plus the counter's enable/reset, locks after
// SYNC_LEN good samples, and reports mismatches and wrap events.
module counter_seq_checker
  import counter_seq_checker_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SYNC_LEN = 3,
  parameter int LOSS_LEN = 2,
  parameter int ERR_W    = DEFAULT_ERR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             cnt_enable,
  input  logic             cnt_reset,
  input  logic             clear_errors,
  output logic             locked,
  output logic             seq_error,
  output logic             wrap,
  output logic [ERR_W-1:0] error_count
);

  localparam logic [3:0] SYNC_LEN_C = 4'(SYNC_LEN);
  localparam logic [3:0] LOSS_LEN_C = 4'(LOSS_LEN);

  state_t           state, state_next;
  logic [WIDTH-1:0] prev_count;
  logic             prev_en, prev_rst;
  logic [3:0]       match_cnt, match_next;
  logic [3:0]       miss_cnt, miss_next;
  logic             locked_next, seq_error_next, wrap_next, err_inc;
  logic [WIDTH-1:0] exp_count;
  logic             match;

  // Counter reset takes priority over enable; the add wraps at WIDTH bits.
  assign exp_count = prev_rst ? '0 : prev_count + WIDTH'(prev_en);
  assign match     = (count_in == exp_count);

  // State, reference sample and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      prev_count <= '0;
      prev_en    <= 1'b0;
      prev_rst   <= 1'b0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      seq_error  <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_next;
      prev_count <= count_in;
      prev_en    <= cnt_enable;
      prev_rst   <= cnt_reset;
      match_cnt  <= match_next;
      miss_cnt   <= miss_next;
      locked     <= locked_next;
      seq_error  <= seq_error_next;
      wrap       <= wrap_next;
    end
  end

  // Next-state and event decode. A mismatch in HUNT needs no explicit resync:
  // the reference registers always take the new sample.
  always_comb begin
    state_next     = state;
    match_next     = match_cnt;
    miss_next      = miss_cnt;
    seq_error_next = 1'b0;
    wrap_next      = 1'b0;
    err_inc        = 1'b0;
    case (state)
      ST_HUNT: begin
        if (match) begin
          if (match_cnt + 4'd1 >= SYNC_LEN_C) begin
            state_next = ST_LOCKED;
            match_next = '0;
            miss_next  = '0;
          end else begin
            match_next = match_cnt + 4'd1;
          end
        end else begin
          match_next = '0;
        end
      end
      ST_LOCKED: begin
        if (match) begin
          miss_next = '0;
          wrap_next = (prev_count == '1) && prev_en && !prev_rst;
        end else begin
          seq_error_next = 1'b1;
          err_inc        = 1'b1;
          if (miss_cnt + 4'd1 >= LOSS_LEN_C) begin
            state_next = ST_HUNT;
            match_next = '0;
            miss_next  = '0;
          end else begin
            miss_next = miss_cnt + 4'd1;
          end
        end
      end
      default: begin
        // IDLE (and the unused encoding): this edge only captures the sample.
        state_next = ST_HUNT;
        match_next = '0;
        miss_next  = '0;
      end
    endcase
    locked_next = (state_next == ST_LOCKED);
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .clear (clear_errors),
    .inc   (err_inc),
    .value (error_count)
  );

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker. A second instance with a 2-bit
// error counter shares the stimulus to exercise saturation.
module tb_counter_seq_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count_in = '0;
  logic       cnt_enable = 1'b0;
  logic       cnt_reset = 1'b0;
  logic       clear_errors = 1'b0;

  logic       locked, seq_error, wrap;
  logic [7:0] error_count;
  logic       locked2, seq_error2, wrap2;
  logic [1:0] error_count2;

  int n_tests = 0;
  int n_fail  = 0;
  int row_idx = 0;

  typedef struct {
    int         idx;
    logic       l;
    logic       s;
    logic       w;
    logic [7:0] e8;
    logic [1:0] e2;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  counter_seq_checker dut (
    .clock(clock), .reset(reset), .count_in(count_in),
    .cnt_enable(cnt_enable), .cnt_reset(cnt_reset), .clear_errors(clear_errors),
    .locked(locked), .seq_error(seq_error), .wrap(wrap), .error_count(error_count)
  );

  counter_seq_checker #(.ERR_W(2)) dut_sat (
    .clock(clock), .reset(reset), .count_in(count_in),
    .cnt_enable(cnt_enable), .cnt_reset(cnt_reset), .clear_errors(clear_errors),
    .locked(locked2), .seq_error(seq_error2), .wrap(wrap2), .error_count(error_count2)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive one sample, let the edge take it, then queue its expected response.
  task automatic row(input logic [3:0] c, input logic en, input logic rst,
                     input logic clr, input logic l, input logic s, input logic w,
                     input logic [7:0] e8, input logic [1:0] e2);
    exp_t e;
    count_in     = c;
    cnt_enable   = en;
    cnt_reset    = rst;
    clear_errors = clr;
    @(posedge clock);
    #1;
    e.idx = row_idx; e.l = l; e.s = s; e.w = w; e.e8 = e8; e.e2 = e2;
    exp_q.push_back(e);
    $display("[TB] row %0d: count=%0d en=%0b rst=%0b clr=%0b", row_idx, c, en, rst, clr);
    row_idx++;
    @(negedge clock);
  endtask

  // Monitor: outputs are valid every cycle, compare away from the active edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("locked", e.idx, 32'(locked), 32'(e.l));
      check("seq_error", e.idx, 32'(seq_error), 32'(e.s));
      check("wrap", e.idx, 32'(wrap), 32'(e.w));
      check("error_count", e.idx, 32'(error_count), 32'(e.e8));
      check("error_count_sat", e.idx, 32'(error_count2), 32'(e.e2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clock);
    #2;
    check("reset_locked", -1, 32'(locked), 0);
    check("reset_seq_error", -1, 32'(seq_error), 0);
    check("reset_wrap", -1, 32'(wrap), 0);
    check("reset_error_count", -1, 32'(error_count), 0);
    check("reset_error_count_sat", -1, 32'(error_count2), 0);

    // Lock acquisition: capture, then three good samples.
    @(negedge clock);
    reset = 1'b1;
    row(4'd7, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    row(4'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    row(4'd1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    row(4'd2, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0);
    // Run through the wrap; the pulse follows the sample of 0.
    for (int v = 3; v <= 15; v++) row(4'(v), 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0);
    row(4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 0);
    for (int v = 1; v <= 6; v++) row(4'(v), 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0);
    // Single glitch 9 instead of 7, then 10 follows 9 and matches.
    row(4'd9, 1'b1, 1'b0, 1'b0, 1, 1, 0, 1, 1);
    row(4'd10, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1, 1);
    // Counter reset with enable also high: reset wins, next value is 0.
    row(4'd11, 1'b1, 1'b1, 1'b0, 1, 0, 0, 1, 1);
    row(4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1, 1);
    for (int v = 1; v <= 4; v++) row(4'(v), 1'b1, 1'b0, 1'b0, 1, 0, 0, 1, 1);
    // Hold violation: 5 held, then 7 and 2 with enable low drop lock.
    row(4'd5, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1, 1);
    row(4'd7, 1'b0, 1'b0, 1'b0, 1, 1, 0, 2, 2);
    row(4'd2, 1'b0, 1'b0, 1'b0, 0, 1, 0, 3, 3);
    // Re-acquire, then push the 2-bit counter into saturation.
    row(4'd2, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3, 3);
    row(4'd3, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3, 3);
    row(4'd4, 1'b1, 1'b0, 1'b0, 1, 0, 0, 3, 3);
    row(4'd9, 1'b1, 1'b0, 1'b0, 1, 1, 0, 4, 3);
    row(4'd10, 1'b1, 1'b0, 1'b0, 1, 0, 0, 4, 3);
    row(4'd0, 1'b1, 1'b0, 1'b0, 1, 1, 0, 5, 3);
    // Clear together with a mismatch leaves 1; clear alone leaves 0.
    row(4'd5, 1'b1, 1'b0, 1'b1, 0, 1, 0, 1, 1);
    row(4'd6, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0);
    row(4'd7, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    row(4'd8, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0);
    for (int v = 9; v <= 15; v++) row(4'(v), 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0);
    row(4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1, 0, 0);
    row(4'd3, 1'b1, 1'b0, 1'b0, 1, 1, 0, 1, 1);

    // Asynchronous reset between edges while locked with an error pending.
    #1;
    reset = 1'b0;
    #1;
    check("async_locked", -2, 32'(locked), 0);
    check("async_seq_error", -2, 32'(seq_error), 0);
    check("async_wrap", -2, 32'(wrap), 0);
    check("async_error_count", -2, 32'(error_count), 0);
    check("async_error_count_sat", -2, 32'(error_count2), 0);
    repeat (2) @(posedge clock);
    #1;
    check("async_hold_locked", -2, 32'(locked), 0);

    // Re-acquire after release.
    @(negedge clock);
    reset = 1'b1;
    row(4'd4, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    row(4'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    row(4'd1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    row(4'd2, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0);

    repeat (3) @(negedge clock);
    check("queue_drained", -3, 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
